// File: rtl/mdu_divider.sv
// -----------------------------------------------------------------------------
// mdu_divider
//   Iterative divide unit for DIV/DIVU. Runs a restoring, one-bit-per-cycle
//   division on operand magnitudes and then applies sign correction. The
//   quotient goes to LO and the remainder to HI. busy stays high for exactly
//   WIDTH+2 cycles after an accepted start, so the PC stage can apply a fixed
//   stall.
//
// Ports
//   DIV_CLK   in   rising-edge clock
//   Reset     in   asynchronous active-low reset
//   start     in   one-cycle request, sampled only while IDLE
//   sign      in   1 = signed (DIV), 0 = unsigned (DIVU), sampled with start
//   dividend  in   rs operand, sampled with start
//   divisor   in   rt operand, sampled with start
//   busy      out  high from the accepting edge until the result edge
//   done      out  one-cycle pulse when q/r are updated
//   div_zero  out  last completed op had a zero divisor (cleared on accept)
//   q         out  quotient, held until the next result edge
//   r         out  remainder, held until the next result edge
//
// Handshake: start is a request that is honoured only when it is sampled
// high in IDLE. Any start seen in LOAD, ITER or FIX (including the cycle that
// raises done) is dropped. Exactly one done pulse follows each accepted start,
// unless Reset aborts the operation, in which case no done is produced.
// -----------------------------------------------------------------------------
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             DIV_CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ITER = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] quot_q, quot_d;     // dividend magnitude shifts out, quotient shifts in
  logic [WIDTH-1:0] rem_q, rem_d;       // partial remainder
  logic [WIDTH-1:0] dvsr_q, dvsr_d;     // raw divisor, then its magnitude after LOAD
  logic [WIDTH-1:0] dvd_q, dvd_d;       // original dividend, kept for the divide-by-zero result
  logic             sign_q, sign_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dz_q, dz_d;         // divide-by-zero detected for the in-flight op
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;

  // Datapath for one restoring step
  logic [WIDTH:0]   shifted;
  logic             no_fit;
  logic [WIDTH-1:0] diff;

  always_ff @(posedge DIV_CLK or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      dvsr_q     <= '0;
      dvd_q      <= '0;
      sign_q     <= 1'b0;
      negq_q     <= 1'b0;
      negr_q     <= 1'b0;
      dz_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      q_q        <= '0;
      r_q        <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dvsr_q     <= dvsr_d;
      dvd_q      <= dvd_d;
      sign_q     <= sign_d;
      negq_q     <= negq_d;
      negr_q     <= negr_d;
      dz_q       <= dz_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      q_q        <= q_d;
      r_q        <= r_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dvsr_d     = dvsr_q;
    dvd_d      = dvd_q;
    sign_d     = sign_q;
    negq_d     = negq_q;
    negr_d     = negr_q;
    dz_d       = dz_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    q_d        = q_q;
    r_d        = r_q;

    // Bring the next dividend bit into the remainder and trial-subtract the
    // divisor. The shifted value can need WIDTH+1 bits, so the fit test is a
    // WIDTH+1-bit compare; when it fits, the difference is below the divisor
    // and therefore fits back into WIDTH bits.
    shifted = {rem_q, quot_q[WIDTH-1]};
    no_fit  = (shifted < {1'b0, dvsr_q});
    diff    = shifted[WIDTH-1:0] - dvsr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d      = dividend;
          dvsr_d     = divisor;
          sign_d     = sign;
          busy_d     = 1'b1;
          div_zero_d = 1'b0;
          state_d    = S_LOAD;
        end
      end

      S_LOAD: begin
        // 0x80000000 negates to itself, which is exactly its unsigned magnitude.
        quot_d  = (sign_q && dvd_q[WIDTH-1])  ? -dvd_q  : dvd_q;
        dvsr_d  = (sign_q && dvsr_q[WIDTH-1]) ? -dvsr_q : dvsr_q;
        negq_d  = sign_q & (dvd_q[WIDTH-1] ^ dvsr_q[WIDTH-1]);
        negr_d  = sign_q & dvd_q[WIDTH-1];
        dz_d    = (dvsr_q == '0);
        rem_d   = '0;
        count_d = '0;
        state_d = S_ITER;
      end

      S_ITER: begin
        if (no_fit) begin
          rem_d  = shifted[WIDTH-1:0];
          quot_d = {quot_q[WIDTH-2:0], 1'b0};
        end else begin
          rem_d  = diff;
          quot_d = {quot_q[WIDTH-2:0], 1'b1};
        end
        if (count_q == LAST_CNT) begin
          state_d = S_FIX;
        end else begin
          count_d = count_q + CW'(1);
        end
      end

      S_FIX: begin
        // A zero divisor still takes the full iteration count so the stall is
        // constant; its architectural result is forced here, independent of sign.
        if (dz_q) begin
          q_d = '1;
          r_d = dvd_q;
        end else begin
          q_d = negq_q ? -quot_q : quot_q;
          r_d = negr_q ? -rem_q  : rem_q;
        end
        div_zero_d = dz_q;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign q        = q_q;
  assign r        = r_q;

endmodule

// File: doc/mdu_divider.md
Name: mdu_divider

Overview:
- Iterative 32-bit divide unit for DIV/DIVU in the MIPS core, sitting beside the execute stage.
- Produces the quotient and remainder that are written to LO and HI.
- Holds `busy` high for exactly WIDTH+2 cycles after `start`; this is the 34-cycle stall the PC stage applies to DIV/DIVU.
- Uses restoring, one-bit-per-cycle division on magnitudes, then sign correction.

Parameters:
- WIDTH, 32, operand/result width. Total latency is WIDTH+2 cycles.

Ports:
- DIV_CLK  input  1  clock, rising-edge.
- Reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  one-cycle request; sampled only in IDLE.
- sign  input  1  1 = DIV (signed), 0 = DIVU (unsigned); sampled with `start`.
- dividend  input  WIDTH  rs operand; sampled with `start`.
- divisor  input  WIDTH  rt operand; sampled with `start`.
- busy  output  1  high from the edge that accepts `start` until the result is ready.
- done  output  1  one-cycle pulse when `q`/`r` become valid.
- div_zero  output  1  divisor was 0 for the last completed op; held until next accept.
- q  output  WIDTH  quotient, to LO.
- r  output  WIDTH  remainder, to HI.

Behaviour:
- Reset (Reset=0, any time, including mid-operation):
  - state goes to IDLE; busy, done, div_zero = 0; q, r = 0.
  - Internal iteration counter, quotient, remainder and divisor registers are cleared.
  - Any in-flight operation is aborted and produces no `done`.
- States: IDLE -> LOAD -> ITER -> FIX -> IDLE.
- IDLE:
  - start=1 at edge T0: latch operands and sign, set busy=1, go to LOAD.
  - start=0: stay in IDLE; q, r, div_zero hold their last values.
- LOAD (1 cycle):
  - Form magnitudes. If sign=1 and the MSB is set, take the two's complement; otherwise pass through.
  - Record neg_q = sign & (dividend MSB ^ divisor MSB) and neg_r = sign & dividend MSB.
  - Clear the partial remainder and set count = 0.
- ITER (exactly WIDTH cycles):
  - Each cycle: shift {partial remainder, quotient} left by 1, bringing in the next dividend bit.
  - Trial subtract uses a WIDTH+1-bit subtractor. If the result is non-negative, keep the difference and set quotient LSB=1; else restore and set quotient LSB=0.
  - count increments; leave ITER when count = WIDTH-1 completes.
- FIX (1 cycle):
  - q = neg_q ? -quot : quot; r = neg_r ? -rem : rem.
  - At the FIX edge (T0+WIDTH+2 = T34): busy drops to 0 and done=1 for one cycle, then return to IDLE.
- Latency: the `start` edge is T0. busy is high for cycles T0..T33 (34 cycles). q/r are valid from T34 and held until the next accepted start.
- Divide by zero (divisor=0):
  - Still runs the full 34 cycles; no early exit, so the PC stall always matches.
  - Result q = all ones, r = original dividend, div_zero = 1. This applies regardless of `sign`.
- Signed overflow (0x80000000 / 0xFFFFFFFF, sign=1): q = 0x80000000, r = 0. This falls out naturally from the unsigned magnitude path; no special case.
- Arithmetic rules:
  - Remainder takes the sign of the dividend.
  - Quotient truncates toward zero.
  - The magnitude of 0x80000000 is treated as unsigned 0x80000000.
- start while busy: ignored; the in-flight operation and its operands are unaffected.
- start in the same cycle as done (FIX->IDLE edge): ignored. A new op is accepted only when start is sampled in IDLE.
- q/r do not change during an operation; they update only at the FIX edge. The last result stays visible for forwarding.

Test Plan:
- Unsigned 100/7 (sign=0):
  - Required: busy high for exactly 34 cycles, done pulses once at T34, q=14, r=2, div_zero=0.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002, sign=1):
  - Required: q=0xFFFFFFFD, r=0xFFFFFFFF.
  - Also 7/-2: q=0xFFFFFFFD, r=0x00000001.
- Edge operands:
  - DIVU 0xFFFFFFFF/2 -> q=0x7FFFFFFF, r=1.
  - DIV 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0.
- Divide by zero, DIV 0x12345678/0:
  - Required: 34 busy cycles, q=0xFFFFFFFF, r=0x12345678, div_zero=1.
  - A following 9/3 op clears div_zero and yields q=3, r=0.
- start pulses during busy (at T5 and at T34) with different operands:
  - Required: ignored; the original result is correct; no extra done pulse.
- Reset=0 asserted at T10 of a 1000/10 op:
  - Required: busy, done, q, r, div_zero immediately 0; no done.
  - After release, a new 1000/10 op gives q=100, r=0 at T34.
